// File: rtl/pc_sequencer.sv
// PC stage ahead of a 1-cycle registered instruction read. Its outputs are registered, so there is no combinational path from input to output.
// Backpressure comes from stall, which freezes the PC and the fetch tags. A redirect takes priority over stall.
module pc_sequencer #(
  parameter int unsigned             REGDATASIZE = 64,
  parameter logic [REGDATASIZE-1:0]  RESET_PC    = '0,
  parameter int unsigned             INSTRNUM    = 1024,
  parameter int unsigned             CNTW        = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [REGDATASIZE-1:0] redirect_target,
  output logic [REGDATASIZE-1:0] addr,
  output logic [REGDATASIZE-1:0] fetch_pc,
  output logic                   fetch_valid,
  output logic                   halted,
  output logic                   fault,
  output logic [CNTW-1:0]        fetch_count
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01
  } state_t;

  localparam logic [REGDATASIZE-1:0] MEM_END = REGDATASIZE'(INSTRNUM) << 2;
  localparam logic [REGDATASIZE-1:0] LAST_PC = MEM_END - REGDATASIZE'(4);

  state_t                   state_q, state_d;
  logic [REGDATASIZE-1:0]   pc_q, pc_d;
  logic [REGDATASIZE-1:0]   fpc_q, fpc_d;
  logic                     fv_q, fv_d;
  logic                     fault_q, fault_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic                     target_ok;
  logic                     state_legal;

  assign target_ok   = (redirect_target[1:0] == 2'b00) && (redirect_target < MEM_END);
  assign state_legal = (state_q == RUN) || (state_q == HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fpc_q   <= '0;
      fv_q    <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fpc_q   <= fpc_d;
      fv_q    <= fv_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fpc_d   = fpc_q;
    fv_d    = fv_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;

    // Count the words handed to decode. A stalled word is counted once, on the edge that releases it.
    if (fv_q && !stall && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end

    if (redirect_valid) begin
      // The word read from the stale pc is squashed whether or not the target is legal.
      fpc_d = pc_q;
      fv_d  = 1'b0;
      if (target_ok) begin
        pc_d    = redirect_target;
        state_d = RUN;
      end else begin
        fault_d = 1'b1;
        state_d = HALT;
      end
    end else if (!stall || !state_legal) begin
      fpc_d = pc_q;
      case (state_q)
        RUN: begin
          fv_d = 1'b1;
          if (pc_q >= LAST_PC) begin
            state_d = HALT;
          end else begin
            pc_d = pc_q + REGDATASIZE'(4);
          end
        end
        HALT: begin
          fv_d = 1'b0;
        end
        default: begin
          fv_d    = 1'b0;
          fault_d = 1'b1;
          state_d = HALT;
        end
      endcase
    end
  end

  assign addr        = pc_q;
  assign fetch_pc    = fpc_q;
  assign fetch_valid = fv_q;
  assign halted      = (state_q == HALT);
  assign fault       = fault_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer. Instance a uses the full-size memory; instance b is small (4 words, 3-bit counter) to exercise the halt and saturation paths.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = '0;

  logic [63:0] a_addr, a_fpc, b_addr, b_fpc;
  logic        a_fv, a_halted, a_fault, b_fv, b_halted, b_fault;
  logic [31:0] a_cnt;
  logic [2:0]  b_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.REGDATASIZE(64), .RESET_PC(64'h0), .INSTRNUM(1024), .CNTW(32)) u_a (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .addr(a_addr), .fetch_pc(a_fpc),
    .fetch_valid(a_fv), .halted(a_halted), .fault(a_fault), .fetch_count(a_cnt));

  pc_sequencer #(.REGDATASIZE(64), .RESET_PC(64'h0), .INSTRNUM(4), .CNTW(3)) u_b (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .addr(b_addr), .fetch_pc(b_fpc),
    .fetch_valid(b_fv), .halted(b_halted), .fault(b_fault), .fetch_count(b_cnt));

  // Reference model: one entry per instance, updated from the architectural rules.
  longint unsigned depth[2] = '{1024, 4};
  longint unsigned cmax[2]  = '{64'hFFFF_FFFF, 64'h7};
  logic [63:0] m_pc[2];
  logic [63:0] m_fpc[2];
  logic [63:0] m_cnt[2];
  logic        m_fv[2];
  logic        m_halt[2];
  logic        m_fault[2];

  task automatic model_reset;
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = '0; m_fpc[i] = '0; m_cnt[i] = '0;
      m_fv[i] = 1'b0; m_halt[i] = 1'b0; m_fault[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input logic stl, input logic rv, input logic [63:0] tgt);
    if (m_fv[i] && !stl && m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
    if (rv) begin
      m_fv[i] = 1'b0;
      if (tgt % 4 == 0 && tgt < depth[i] * 4) begin
        m_pc[i] = tgt; m_halt[i] = 1'b0;
      end else begin
        m_fault[i] = 1'b1; m_halt[i] = 1'b1;
      end
    end else if (!stl) begin
      if (m_halt[i]) begin
        m_fv[i] = 1'b0;
      end else begin
        m_fpc[i] = m_pc[i];
        m_fv[i]  = 1'b1;
        if (m_pc[i] == depth[i] * 4 - 4) m_halt[i] = 1'b1;
        else m_pc[i] = m_pc[i] + 4;
      end
    end
  endtask

  // fetch_pc is only meaningful while the model says the word is valid.
  function automatic logic [194:0] exp_v(input int i);
    return {m_pc[i], m_fv[i] ? m_fpc[i] : 64'h0, m_fv[i], m_halt[i], m_fault[i], m_cnt[i]};
  endfunction

  function automatic logic [194:0] obs(input int i);
    if (i == 0) return {a_addr, m_fv[0] ? a_fpc : 64'h0, a_fv, a_halted, a_fault, 32'h0, a_cnt};
    return {b_addr, m_fv[1] ? b_fpc : 64'h0, b_fv, b_halted, b_fault, 61'h0, b_cnt};
  endfunction

  task automatic cyc(input logic stl, input logic rv, input logic [63:0] tgt);
    stall = stl; redirect_valid = rv; redirect_target = tgt;
    for (int i = 0; i < 2; i++) model_step(i, stl, rv, tgt);
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset;
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_addr, a_fpc, a_fv, a_halted, a_fault, a_cnt} !== 163'h0) begin
      n_err++;
      $display("FAIL reset_a got addr=%h fpc=%h fv=%b h=%b f=%b cnt=%0d want all zero",
               a_addr, a_fpc, a_fv, a_halted, a_fault, a_cnt);
    end
    n_cmp++;
    if ({b_addr, b_fpc, b_fv, b_halted, b_fault, b_cnt} !== 134'h0) begin
      n_err++;
      $display("FAIL reset_b got addr=%h fpc=%h fv=%b h=%b f=%b cnt=%0d want all zero",
               b_addr, b_fpc, b_fv, b_halted, b_fault, b_cnt);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_sequential;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc(1'b0, 1'b0, 64'h0);
      n_cmp++;
      if (a_addr !== 64'(4 * k) || a_fv !== (k > 0) || (k > 0 && a_fpc !== 64'(4 * (k - 1)))) begin
        n_err++;
        $display("FAIL seq_table k=%0d got addr=%h fv=%b fpc=%h want addr=%h fv=%b fpc=%h",
                 k, a_addr, a_fv, a_fpc, 64'(4 * k), (k > 0), 64'(4 * (k - 1)));
      end
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== exp_v(i)) begin
          n_err++;
          $display("FAIL seq_model dut%0d k=%0d got %h want %h", i, k, obs(i), exp_v(i));
        end
      end
    end
  endtask

  task automatic test_stall;
    do_reset();
    cyc(1'b0, 1'b0, 64'h0);
    cyc(1'b0, 1'b0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 64'h0);
      n_cmp++;
      if (a_addr !== 64'h8 || a_fpc !== 64'h4 || a_fv !== 1'b1 || a_cnt !== 32'd1) begin
        n_err++;
        $display("FAIL stall_hold k=%0d got addr=%h fpc=%h fv=%b cnt=%0d want 8/4/1/1",
                 k, a_addr, a_fpc, a_fv, a_cnt);
      end
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0, 64'h0);
      n_cmp++;
      if (a_addr !== 64'(12 + 4 * k) || a_fpc !== 64'(8 + 4 * k)) begin
        n_err++;
        $display("FAIL stall_resume k=%0d got addr=%h fpc=%h want %h/%h",
                 k, a_addr, a_fpc, 64'(12 + 4 * k), 64'(8 + 4 * k));
      end
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== exp_v(i)) begin
          n_err++;
          $display("FAIL stall_model dut%0d got %h want %h", i, obs(i), exp_v(i));
        end
      end
    end
  endtask

  task automatic test_redirect_stall;
    // Instance a sits at addr 0x10 here; redirect arrives while stall is held.
    cyc(1'b1, 1'b1, 64'h40);
    n_cmp++;
    if (a_addr !== 64'h40 || a_fv !== 1'b0 || a_halted !== 1'b0) begin
      n_err++;
      $display("FAIL redir_squash got addr=%h fv=%b halted=%b want 40/0/0", a_addr, a_fv, a_halted);
    end
    cyc(1'b0, 1'b0, 64'h0);
    n_cmp++;
    if (a_fpc !== 64'h40 || a_fv !== 1'b1 || a_addr !== 64'h44) begin
      n_err++;
      $display("FAIL redir_first got fpc=%h fv=%b addr=%h want 40/1/44", a_fpc, a_fv, a_addr);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs(i) !== exp_v(i)) begin
        n_err++;
        $display("FAIL redir_model dut%0d got %h want %h", i, obs(i), exp_v(i));
      end
    end
  endtask

  task automatic test_end_of_memory;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b0, 64'h0);
      n_cmp++;
      if (b_fv !== (k <= 4) || b_halted !== (k >= 4) ||
          (k <= 4 && b_fpc !== 64'(4 * (k - 1))) || b_addr !== 64'(k < 4 ? 4 * k : 12)) begin
        n_err++;
        $display("FAIL eom_run k=%0d got fv=%b halted=%b fpc=%h addr=%h", k, b_fv, b_halted, b_fpc, b_addr);
      end
    end
    cyc(1'b0, 1'b1, 64'h0);
    n_cmp++;
    if (b_fv !== 1'b0 || b_halted !== 1'b0 || b_addr !== 64'h0) begin
      n_err++;
      $display("FAIL eom_restart got fv=%b halted=%b addr=%h want 0/0/0", b_fv, b_halted, b_addr);
    end
    cyc(1'b0, 1'b0, 64'h0);
    n_cmp++;
    if (b_fv !== 1'b1 || b_fpc !== 64'h0 || b_addr !== 64'h4) begin
      n_err++;
      $display("FAIL eom_resume got fv=%b fpc=%h addr=%h want 1/0/4", b_fv, b_fpc, b_addr);
    end
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 64'h0);
    n_cmp++;
    if (b_cnt !== 3'd7) begin
      n_err++;
      $display("FAIL sat_cnt got %0d want 7", b_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs(i) !== exp_v(i)) begin
        n_err++;
        $display("FAIL sat_model dut%0d got %h want %h", i, obs(i), exp_v(i));
      end
    end
  endtask

  task automatic test_fault;
    logic [63:0] bad[2];
    bad[0] = 64'h42;
    bad[1] = 64'd4096;
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 64'h0);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b1, bad[k]);
      n_cmp++;
      if (a_fault !== 1'b1 || a_halted !== 1'b1 || a_addr !== 64'hC || a_fv !== 1'b0) begin
        n_err++;
        $display("FAIL fault_bad tgt=%h got fault=%b halted=%b addr=%h fv=%b want 1/1/c/0",
                 bad[k], a_fault, a_halted, a_addr, a_fv);
      end
    end
    cyc(1'b0, 1'b1, 64'h8);
    n_cmp++;
    if (a_fault !== 1'b1 || a_halted !== 1'b0 || a_addr !== 64'h8) begin
      n_err++;
      $display("FAIL fault_restart got fault=%b halted=%b addr=%h want 1/0/8", a_fault, a_halted, a_addr);
    end
    cyc(1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs(i) !== exp_v(i)) begin
        n_err++;
        $display("FAIL fault_model dut%0d got %h want %h", i, obs(i), exp_v(i));
      end
    end
  endtask

  task automatic test_async_reset;
    for (int s = 0; s < 2; s++) begin
      do_reset();
      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 64'h0);
      cyc(1'b0, 1'b1, 64'h3);
      cyc(1'b0, 1'b1, 64'h20);
      cyc(1'b0, 1'b0, 64'h0);
      stall = (s == 0);
      redirect_valid = (s == 1);
      redirect_target = 64'h40;
      #3 reset = 1'b0;
      #1;
      n_cmp++;
      if ({a_addr, a_fpc, a_fv, a_halted, a_fault, a_cnt} !== 163'h0 ||
          {b_addr, b_fpc, b_fv, b_halted, b_fault, b_cnt} !== 134'h0) begin
        n_err++;
        $display("FAIL async_reset case=%0d got a=%h/%h/%b/%b/%b/%0d b=%h/%h/%b/%b/%b/%0d want zeros",
                 s, a_addr, a_fpc, a_fv, a_halted, a_fault, a_cnt,
                 b_addr, b_fpc, b_fv, b_halted, b_fault, b_cnt);
      end
      stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      #1 reset = 1'b1;
      model_reset();
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) model_step(i, 1'b0, 1'b0, 64'h0);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== exp_v(i)) begin
          n_err++;
          $display("FAIL async_after dut%0d got %h want %h", i, obs(i), exp_v(i));
        end
      end
    end
  endtask

  task automatic test_random;
    logic        stl, rv;
    logic [63:0] tgt;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      stl = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = 64'($urandom_range(0, 3)) * 4;
        1:       tgt = 64'($urandom_range(0, 1023)) * 4;
        2:       tgt = 64'($urandom_range(0, 1023)) * 4 + 64'($urandom_range(1, 3));
        default: tgt = 64'h1000 + 64'($urandom_range(0, 255)) * 4;
      endcase
      cyc(stl, rv, tgt);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== exp_v(i)) begin
          n_err++;
          $display("FAIL random dut%0d n=%0d got %h want %h", i, n, obs(i), exp_v(i));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_end_of_memory();
    test_saturation();
    test_fault();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
